// File: rtl/pll_rst_seq.sv
// ============================================================================
// Module   : pll_rst_seq
// Purpose  : PLL reset / lock sequencer. Runs on the PLL reference clock,
//            holds the PLL in reset at power-up, waits for a filtered lock,
//            then releases core reset. Loss of lock re-sequences; a bounded
//            number of lock timeouts parks the block in FAIL.
// Ports    : clk        - reference (pad) clock, valid before lock
//            reset      - asynchronous active-low block reset
//            pll_lock   - PLL LOCK, asynchronous to clk
//            soft_rst   - (optional) active-high level soft reset, clk domain
//            pll_resetb - active-low PLL reset (registered)
//            core_rst_n - active-low core reset, clk domain (registered)
//            ready      - high only in RUN
//            lock_lost  - sticky, set on lock drop in HOLD or RUN
//            fail       - high in FAIL
//            retry_cnt  - lock timeouts so far, saturating at 255
// Options  : define PLL_RST_SEQ_SOFT_RST_EN to add the soft_rst input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_rst_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILT      = 8,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int CORE_RST_DLY   = 4,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
`ifdef PLL_RST_SEQ_SOFT_RST_EN
  input  logic       soft_rst,
`endif
  output logic       pll_resetb,
  output logic       core_rst_n,
  output logic       ready,
  output logic       lock_lost,
  output logic       fail,
  output logic [7:0] retry_cnt
);

  // Counter widths; a parameter of 1 still needs a 1-bit counter.
  localparam int RW = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
  localparam int FW = (LOCK_FILT      > 1) ? $clog2(LOCK_FILT)      : 1;
  localparam int TW = (LOCK_TIMEOUT   > 1) ? $clog2(LOCK_TIMEOUT)   : 1;
  localparam int DW = (CORE_RST_DLY   > 1) ? $clog2(CORE_RST_DLY)   : 1;

  localparam logic [RW-1:0] RST_LAST  = RW'(PLL_RST_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [DW-1:0] HOLD_LAST = DW'(CORE_RST_DLY - 1);
  localparam logic [7:0]    MAX_RETRY_B = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [1:0]    sync;
  logic          lock_s;
  logic [RW-1:0] rst_cnt,  rst_cnt_n;
  logic [FW-1:0] filt_cnt, filt_cnt_n;
  logic [TW-1:0] tmo_cnt,  tmo_cnt_n;
  logic [DW-1:0] hold_cnt, hold_cnt_n;
  logic [7:0]    retry_n, retry_inc;
  logic          lost_n, timeout, filt_done;

  assign lock_s = sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync       <= 2'b00;
      state      <= S_PLL_RST;
      rst_cnt    <= '0;
      filt_cnt   <= '0;
      tmo_cnt    <= '0;
      hold_cnt   <= '0;
      retry_cnt  <= 8'd0;
      lock_lost  <= 1'b0;
      pll_resetb <= 1'b0;
      core_rst_n <= 1'b0;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      sync       <= {sync[0], pll_lock};
      state      <= state_n;
      rst_cnt    <= rst_cnt_n;
      filt_cnt   <= filt_cnt_n;
      tmo_cnt    <= tmo_cnt_n;
      hold_cnt   <= hold_cnt_n;
      retry_cnt  <= retry_n;
      lock_lost  <= lost_n;
      // Outputs are decoded from the next state so they come straight off flops.
      pll_resetb <= !((state_n == S_PLL_RST) || (state_n == S_FAIL));
      core_rst_n <= (state_n == S_RUN);
      ready      <= (state_n == S_RUN);
      fail       <= (state_n == S_FAIL);
    end
  end

  always_comb begin
    state_n    = state;
    rst_cnt_n  = rst_cnt;
    filt_cnt_n = filt_cnt;
    tmo_cnt_n  = tmo_cnt;
    hold_cnt_n = hold_cnt;
    retry_n    = retry_cnt;
    lost_n     = lock_lost;
    retry_inc  = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;
    timeout    = (tmo_cnt == TMO_LAST);
    // From WAIT_LOCK the first high sample is filter count 1.
    filt_done  = (state == S_WAIT_LOCK) ? (LOCK_FILT <= 1) : (filt_cnt == FILT_LAST);

    case (state)
      S_PLL_RST: begin
        if (rst_cnt == RST_LAST) begin
          state_n   = S_WAIT_LOCK;
          rst_cnt_n = '0;
          tmo_cnt_n = '0;
        end else begin
          rst_cnt_n = rst_cnt + RW'(1);
        end
      end
      // The timeout counter spans both states so a flickering lock cannot
      // postpone the per-attempt timeout indefinitely. Timeout has priority.
      S_WAIT_LOCK, S_FILTER: begin
        if (timeout) begin
          retry_n    = retry_inc;
          tmo_cnt_n  = '0;
          filt_cnt_n = '0;
          state_n    = (retry_inc >= MAX_RETRY_B) ? S_FAIL : S_PLL_RST;
        end else begin
          tmo_cnt_n = tmo_cnt + TW'(1);
          if (!lock_s) begin
            state_n    = S_WAIT_LOCK;
            filt_cnt_n = '0;
          end else if (filt_done) begin
            state_n    = S_HOLD;
            filt_cnt_n = '0;
            hold_cnt_n = '0;
          end else begin
            state_n    = S_FILTER;
            filt_cnt_n = (state == S_WAIT_LOCK) ? FW'(1) : filt_cnt + FW'(1);
          end
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          lost_n     = 1'b1;
          state_n    = S_PLL_RST;
          hold_cnt_n = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n    = S_RUN;
          hold_cnt_n = '0;
        end else begin
          hold_cnt_n = hold_cnt + DW'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          lost_n  = 1'b1;
          state_n = S_PLL_RST;
        end
      end
      S_FAIL: begin
        state_n = S_FAIL;
      end
      default: begin
        state_n = S_PLL_RST;
      end
    endcase

`ifdef PLL_RST_SEQ_SOFT_RST_EN
    // Soft reset overrides every state; lock_lost history is kept.
    if (soft_rst) begin
      state_n    = S_PLL_RST;
      rst_cnt_n  = '0;
      filt_cnt_n = '0;
      tmo_cnt_n  = '0;
      hold_cnt_n = '0;
      retry_n    = 8'd0;
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_pll_rst_seq.sv
// ============================================================================
// Module   : tb_pll_rst_seq
// Purpose  : Self-checking bench for pll_rst_seq. Each scenario builds a
//            per-cycle PLL_LOCK waveform, derives the expected per-cycle
//            outputs from an event-level timeline model, and compares the
//            DUT cycle by cycle. Cycle k = k-th rising edge after reset
//            release; PLL_LOCK value L[k] is applied just after edge k.
// Ports    : none (top-level bench)
// Options  : PLL_RST_SEQ_SOFT_RST_EN enables the soft-reset scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_rst_seq;

  localparam int P_R    = 16;
  localparam int P_F    = 8;
  localparam int P_T    = 200;
  localparam int P_D    = 4;
  localparam int P_MAXR = 3;
  localparam int MAXN   = 11000;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
`ifdef PLL_RST_SEQ_SOFT_RST_EN
  logic       soft_rst;
`endif
  logic       pll_resetb, core_rst_n, ready, lock_lost, fail;
  logic [7:0] retry_cnt;

  int n_cmp = 0;
  int n_err = 0;

  bit         L      [0:MAXN];
  bit         e_rb   [0:MAXN];
  bit         e_core [0:MAXN];
  bit         e_rdy  [0:MAXN];
  bit         e_fail [0:MAXN];
  bit         e_lost [0:MAXN];
  logic [7:0] e_retry[0:MAXN];

  int obs_rb_rise, obs_core_rise, obs_core_fall;

  always #5 clk = ~clk;

  pll_rst_seq #(
    .PLL_RST_CYCLES(P_R),
    .LOCK_FILT     (P_F),
    .LOCK_TIMEOUT  (P_T),
    .CORE_RST_DLY  (P_D),
    .MAX_RETRY     (P_MAXR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pll_lock  (pll_lock),
`ifdef PLL_RST_SEQ_SOFT_RST_EN
    .soft_rst  (soft_rst),
`endif
    .pll_resetb(pll_resetb),
    .core_rst_n(core_rst_n),
    .ready     (ready),
    .lock_lost (lock_lost),
    .fail      (fail),
    .retry_cnt (retry_cnt)
  );

  // Lock as seen by the sequencer at edge j (two-flop synchronizer + decision edge).
  function automatic bit seen(input int j);
    return (j >= 3) ? L[j-3] : 1'b0;
  endfunction

  task automatic clear_lock();
    for (int k = 0; k <= MAXN; k++) L[k] = 1'b0;
  endtask

  task automatic fill(input int a, input int b, input bit rb, input bit core,
                      input bit rdy, input bit fl, input bit lost, input int retry,
                      input int n);
    for (int j = a; j < b && j <= n; j++) begin
      e_rb[j] = rb; e_core[j] = core; e_rdy[j] = rdy; e_fail[j] = fl;
      e_lost[j] = lost; e_retry[j] = 8'(retry);
    end
  endtask

  // Timeline model: each attempt = reset window, lock search bounded by the
  // timeout, core-reset delay, then run until the lock drops.
  task automatic model(input int n);
    int t, w, h, r, drop, run, lim, retry;
    bit lost, done;
    t = 0; retry = 0; lost = 1'b0; done = 1'b0;
    while (!done) begin
      w = t + P_R;
      fill(t, w, 0, 0, 0, 0, lost, retry, n);
      if (w > n) begin done = 1'b1; continue; end
      h = -1; run = 0;
      lim = (w + P_T - 1 < n) ? w + P_T - 1 : n;
      for (int j = w + 1; j <= lim; j++) begin
        run = seen(j) ? run + 1 : 0;
        if (run >= P_F) begin h = j; break; end
      end
      if (h < 0) begin
        if (w + P_T > n) begin fill(w, n + 1, 1, 0, 0, 0, lost, retry, n); done = 1'b1; continue; end
        fill(w, w + P_T, 1, 0, 0, 0, lost, retry, n);
        retry = (retry < 255) ? retry + 1 : 255;
        if (retry >= P_MAXR) begin fill(w + P_T, n + 1, 0, 0, 0, 1, lost, retry, n); done = 1'b1; continue; end
        t = w + P_T;
        continue;
      end
      fill(w, h, 1, 0, 0, 0, lost, retry, n);
      drop = -1;
      for (int j = h + 1; j <= h + P_D && j <= n; j++)
        if (!seen(j)) begin drop = j; break; end
      if (drop >= 0) begin fill(h, drop, 1, 0, 0, 0, lost, retry, n); lost = 1'b1; t = drop; continue; end
      if (h + P_D > n) begin fill(h, n + 1, 1, 0, 0, 0, lost, retry, n); done = 1'b1; continue; end
      r = h + P_D;
      fill(h, r, 1, 0, 0, 0, lost, retry, n);
      drop = -1;
      for (int j = r + 1; j <= n; j++)
        if (!seen(j)) begin drop = j; break; end
      if (drop < 0) begin fill(r, n + 1, 1, 1, 1, 0, lost, retry, n); done = 1'b1; continue; end
      fill(r, drop, 1, 1, 1, 0, lost, retry, n);
      lost = 1'b1; t = drop;
    end
  endtask

  // Reset, release mid-cycle, then drive L[] and compare every cycle.
  // abort_at >= 0 asserts reset between edges after that cycle and checks it.
  task automatic run(input string name, input int n, input int abort_at);
    logic [12:0] got, exp;
    reset = 1'b0; pll_lock = 1'b0;
`ifdef PLL_RST_SEQ_SOFT_RST_EN
    soft_rst = 1'b0;
`endif
    obs_rb_rise = -1; obs_core_rise = -1; obs_core_fall = -1;
    @(posedge clk); #2;
    n_cmp++;
    if ({pll_resetb, core_rst_n, ready, lock_lost, fail, retry_cnt} !== 13'b0) begin
      n_err++;
      $display("FAIL %s reset_values: got rb=%b core=%b rdy=%b lost=%b fail=%b retry=%0d, expected all 0",
               name, pll_resetb, core_rst_n, ready, lock_lost, fail, retry_cnt);
    end
    @(posedge clk); #2 reset = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      got = {pll_resetb, core_rst_n, ready, lock_lost, fail, retry_cnt};
      exp = {e_rb[k], e_core[k], e_rdy[k], e_lost[k], e_fail[k], e_retry[k]};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s cycle %0d: got rb=%b core=%b rdy=%b lost=%b fail=%b retry=%0d, expected rb=%b core=%b rdy=%b lost=%b fail=%b retry=%0d",
                 name, k, got[12], got[11], got[10], got[9], got[8], got[7:0],
                 exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
      end
      if (obs_rb_rise < 0 && pll_resetb === 1'b1) obs_rb_rise = k;
      if (obs_core_rise < 0 && core_rst_n === 1'b1) obs_core_rise = k;
      if (obs_core_rise >= 0 && obs_core_fall < 0 && core_rst_n === 1'b0) obs_core_fall = k;
      pll_lock = L[k];
      if (k == abort_at) begin
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({pll_resetb, core_rst_n, ready, lock_lost, fail, retry_cnt} !== 13'b0) begin
          n_err++;
          $display("FAIL %s async_reset_midcycle: got rb=%b core=%b rdy=%b lost=%b fail=%b retry=%0d, expected all 0",
                   name, pll_resetb, core_rst_n, ready, lock_lost, fail, retry_cnt);
        end
        return;
      end
    end
  endtask

  task automatic test_reset();
    clear_lock();
    model(30);
    run("reset", 30, -1);
  endtask

  task automatic test_power_up();
    clear_lock();
    for (int k = 40; k <= 120; k++) L[k] = 1'b1;
    model(120);
    run("power_up", 120, -1);
    n_cmp++;
    if (obs_rb_rise != 16) begin n_err++; $display("FAIL power_up pll_resetb_rise: got %0d, expected 16", obs_rb_rise); end
    n_cmp++;
    if (obs_core_rise != 54) begin n_err++; $display("FAIL power_up core_rise: got %0d, expected 54", obs_core_rise); end
  endtask

  task automatic test_glitch();
    clear_lock();
    for (int k = 40; k <= 44; k++) L[k] = 1'b1;
    for (int k = 48; k <= 120; k++) L[k] = 1'b1;
    model(120);
    run("glitch", 120, -1);
    n_cmp++;
    if (obs_core_rise != 62) begin n_err++; $display("FAIL glitch core_rise: got %0d, expected 62", obs_core_rise); end
  endtask

  task automatic test_timeout();
    int n;
    n = 3 * (P_R + P_T) + 10000;
    clear_lock();
    model(n);
    run("timeout", n, -1);
    n_cmp++;
    if ({fail, pll_resetb, retry_cnt} !== {1'b1, 1'b0, 8'd3}) begin
      n_err++;
      $display("FAIL timeout final: got fail=%b rb=%b retry=%0d, expected fail=1 rb=0 retry=3",
               fail, pll_resetb, retry_cnt);
    end
  endtask

  task automatic test_lock_loss();
    clear_lock();
    for (int k = 40; k <= 200; k++) L[k] = 1'b1;
    L[100] = 1'b0;
    model(200);
    run("lock_loss", 200, -1);
    n_cmp++;
    if (obs_core_fall != 103) begin n_err++; $display("FAIL lock_loss core_fall: got %0d, expected 103", obs_core_fall); end
    n_cmp++;
    if ({ready, lock_lost, retry_cnt} !== {1'b1, 1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL lock_loss final: got rdy=%b lost=%b retry=%0d, expected rdy=1 lost=1 retry=0",
               ready, lock_lost, retry_cnt);
    end
  endtask

  task automatic test_async_reset();
    clear_lock();
    for (int k = 20; k <= 100; k++) L[k] = 1'b1;
    model(100);
    run("async_hold", 100, 31);   // HOLD spans cycles 30..33 for this waveform
    run("async_replay", 100, -1);
  endtask

  task automatic test_random();
    int k, len;
    bit v;
    for (int it = 0; it < 4; it++) begin
      clear_lock();
      k = 1; v = 1'($urandom_range(0, 1));
      while (k <= 1500) begin
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 260) : $urandom_range(1, 20);
        for (int i = 0; i < len && k <= 1500; i++) begin L[k] = v; k++; end
        v = !v;
      end
      model(1500);
      run("random", 1500, -1);
    end
  endtask

`ifdef PLL_RST_SEQ_SOFT_RST_EN
  task automatic test_soft_rst();
    clear_lock();
    model(660);
    run("soft_pre", 660, -1);     // FAIL entered at cycle 648
    soft_rst = 1'b1;
    @(posedge clk); #1;           // cycle 661
    n_cmp++;
    if ({fail, retry_cnt, pll_resetb} !== {1'b0, 8'd0, 1'b0}) begin
      n_err++;
      $display("FAIL soft_rst clear: got fail=%b retry=%0d rb=%b, expected fail=0 retry=0 rb=0",
               fail, retry_cnt, pll_resetb);
    end
    @(posedge clk); #1;           // cycle 662
    soft_rst = 1'b0;
    pll_lock = 1'b1;
    for (int k = 663; k <= 692; k++) begin
      @(posedge clk); #1;
      if (k == 677 || k == 678) begin
        n_cmp++;
        if (pll_resetb !== (k == 678)) begin
          n_err++;
          $display("FAIL soft_rst rb cycle %0d: got %b, expected %b", k, pll_resetb, (k == 678));
        end
      end
      if (k == 689 || k == 690) begin
        n_cmp++;
        if ({core_rst_n, ready, lock_lost, fail} !== {(k == 690), (k == 690), 1'b0, 1'b0}) begin
          n_err++;
          $display("FAIL soft_rst core cycle %0d: got core=%b rdy=%b lost=%b fail=%b, expected core=%b",
                   k, core_rst_n, ready, lock_lost, fail, (k == 690));
        end
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    pll_lock = 1'b0;
`ifdef PLL_RST_SEQ_SOFT_RST_EN
    soft_rst = 1'b0;
`endif
    test_reset();
    test_power_up();
    test_glitch();
    test_timeout();
    test_lock_loss();
    test_async_reset();
    test_random();
`ifdef PLL_RST_SEQ_SOFT_RST_EN
    test_soft_rst();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Reset/lock sequencer on the other side of the PLL wrapper. It drives the PLL's active-low RESETB and consumes its LOCK output.
- Runs on the PLL reference (pad) clock, which is valid before lock.
- Holds the PLL in reset at power-up, waits for a filtered lock, then releases core reset.
- Detects loss of lock and re-sequences. Gives up after a bounded number of retries.

Parameters:
- PLL_RST_CYCLES, 16, cycles PLL_RESETB is held low per attempt (>=1).
- LOCK_FILT, 8, consecutive synchronized LOCK-high cycles required (>=1).
- LOCK_TIMEOUT, 65535, cycles allowed in WAIT_LOCK/FILTER per attempt before retry.
- CORE_RST_DLY, 4, cycles between filtered lock and core reset release (>=1).
- MAX_RETRY, 3, failed attempts before entering FAIL (1..255).

Ports:
- CLK  input  1  reference clock (12 MHz pad clock, same source as PLL input).
- RESET  input  1  asynchronous, active-low block reset.
- PLL_LOCK  input  1  PLL LOCK; asynchronous to CLK.
- PLL_RESETB  output  1  active-low PLL reset; connects to PLL wrapper RESET.
- CORE_RST_N  output  1  active-low core reset, CLK domain; consumers resynchronize into the PLL clock domain.
- READY  output  1  high only in RUN.
- LOCK_LOST  output  1  sticky; set on any lock drop in HOLD or RUN.
- FAIL  output  1  high in FAIL state.
- RETRY_CNT  output  8  timeouts so far; saturates at 255.

Behaviour:
- Reset is asynchronous and active-low on RESET. All other logic is synchronous to the CLK rising edge.
- Reset values: state=PLL_RST, all counters 0, PLL_RESETB=0, CORE_RST_N=0, READY=0, LOCK_LOST=0, FAIL=0, RETRY_CNT=0. The synchronizer flops also reset to 0.
- PLL_LOCK passes through a 2-flop synchronizer to give lock_s. All state decisions use lock_s only.
- All outputs are registered. No output may glitch.
- PLL_RST:
  - PLL_RESETB=0, CORE_RST_N=0.
  - After PLL_RST_CYCLES cycles, go to WAIT_LOCK and clear the timeout counter.
  - PLL_RESETB rises exactly PLL_RST_CYCLES cycles after RESET deasserts.
- WAIT_LOCK:
  - PLL_RESETB=1. The timeout counter increments every cycle.
  - lock_s=1: go to FILTER with filter count 1.
  - Timeout counter reaches LOCK_TIMEOUT-1 (timeout):
    - RETRY_CNT increments, saturating.
    - If the new RETRY_CNT >= MAX_RETRY, go to FAIL; otherwise go to PLL_RST.
- FILTER:
  - The timeout counter keeps running and is not cleared.
  - lock_s=1: filter count increments.
  - lock_s=0: return to WAIT_LOCK.
  - Filter count reaches LOCK_FILT: go to HOLD.
  - Timeout in the same cycle as filter completion: timeout wins.
- HOLD:
  - CORE_RST_N stays 0. Wait CORE_RST_DLY cycles, then go to RUN.
  - lock_s=0: set LOCK_LOST and go to PLL_RST. RETRY_CNT is unchanged.
- RUN:
  - CORE_RST_N=1, READY=1.
  - lock_s=0: on the next edge CORE_RST_N=0, READY=0, LOCK_LOST=1, state=PLL_RST.
  - Lock drops do not count as retries.
- FAIL: PLL_RESETB=0, CORE_RST_N=0, FAIL=1. Terminal; exit only by RESET.
- End-to-end latency: PLL_LOCK rising at a CLK edge, held high, gives a CORE_RST_N rise exactly 2+LOCK_FILT+CORE_RST_DLY cycles later (14 with defaults).
- A lock pulse shorter than LOCK_FILT synchronized cycles never releases core reset.
- RESET asserted mid-sequence forces reset values immediately, including from FAIL and RUN.
- Counter widths are sized by $clog2 of the respective parameter. No counter wraps: each is cleared on every state entry.

Optional Feature:
- Macro: PLL_RST_SEQ_SOFT_RST_EN.
- Defined:
  - Adds input SOFT_RST (1 bit, CLK domain, active-high, level).
  - While high, the block is forced to PLL_RST with counters, RETRY_CNT and FAIL cleared. LOCK_LOST is preserved.
  - Sequencing restarts on the first cycle after SOFT_RST falls.
  - Honoured in every state, including FAIL.
- Undefined: the port is absent and FAIL is exitable only by RESET.

Test Plan:
- Power-up, defaults, PLL_LOCK rises at cycle 40 and stays high -> PLL_RESETB rises at cycle 16; CORE_RST_N and READY rise at cycle 54; RETRY_CNT=0, LOCK_LOST=0.
- Glitch: PLL_LOCK high for 5 cycles, low for 3, then steady high -> no release during the glitch; CORE_RST_N rises 14 cycles after the final rising edge.
- Timeout (bench override LOCK_TIMEOUT=200, MAX_RETRY=3), PLL_LOCK held 0 -> RETRY_CNT steps 1,2,3 and PLL_RESETB pulses low 16 cycles each time. After the third timeout: FAIL=1, PLL_RESETB=0, and the state stays put for 10000 cycles.
- Lock loss in RUN: drop PLL_LOCK for 1 cycle -> CORE_RST_N=0 and READY=0 exactly 3 cycles after the drop. LOCK_LOST=1 sticky, PLL_RESETB low for 16 cycles, RETRY_CNT unchanged, READY returns after relock.
- Async reset mid-HOLD: assert RESET between CLK edges -> all outputs at reset values before the next edge; full sequence replays on release.
- With PLL_RST_SEQ_SOFT_RST_EN, from FAIL pulse SOFT_RST 2 cycles -> FAIL=0, RETRY_CNT=0, PLL_RESETB low 16 cycles after SOFT_RST falls, normal lock sequence follows.
